// File: rtl/qfpga_dispatch_arbiter_if.sv
// qfpga_dispatch_arbiter_if: issue-lane request bundle and dispatch-register output bundle
interface qfpga_dispatch_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_FPGA = 64,
  parameter int INSTR_W  = 56,
  parameter int CNT_W    = 32
);
  localparam int FW = $clog2(NUM_FPGA);
  localparam int SW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*FW-1:0]      req_fpga;
  logic [NUM_REQ*INSTR_W-1:0] req_instr;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [FW-1:0]              out_fpga;
  logic [INSTR_W-1:0]         out_instr;
  logic [SW-1:0]              out_src;
  logic [NUM_FPGA-1:0]        fpga_busy;
  logic [CNT_W-1:0]           issue_cnt;
  modport master (
    input  req_valid, req_fpga, req_instr, out_ready,
    output req_ready, out_valid, out_fpga, out_instr, out_src, fpga_busy, issue_cnt
  );
  modport slave (
    output req_valid, req_fpga, req_instr, out_ready,
    input  req_ready, out_valid, out_fpga, out_instr, out_src, fpga_busy, issue_cnt
  );
endinterface

// File: rtl/qfpga_dispatch_arbiter.sv
// qfpga_dispatch_arbiter: round-robin share of the dispatch port, skipping FPGAs still executing a gate
module qfpga_dispatch_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int NUM_FPGA           = 64,
  parameter int NUM_QUBIT_PER_FPGA = 64,
  parameter int INSTR_W            = 3*$clog2(NUM_FPGA*NUM_QUBIT_PER_FPGA)+20,
  parameter int GATE_LAT           = 8,
  parameter int CNT_W              = 32
) (
  input logic clk,
  input logic rst,
  qfpga_dispatch_arbiter_if.master bus
);
  localparam int FW = $clog2(NUM_FPGA);
  localparam int SW = $clog2(NUM_REQ);
  localparam int BW = GATE_LAT > 0 ? $clog2(GATE_LAT+1) : 1;
  logic [BW-1:0]       bcnt [NUM_FPGA];
  logic [SW-1:0]       rr_ptr, win, out_src;
  logic [NUM_REQ-1:0]  elig, gnt;
  logic [NUM_FPGA-1:0] busy;
  logic                found, hs, free, out_valid;
  logic [FW-1:0]       out_fpga;
  logic [INSTR_W-1:0]  out_instr;
  logic [CNT_W-1:0]    issue_cnt;
  int                  idx;
  assign hs   = out_valid & bus.out_ready;
  assign free = !out_valid | bus.out_ready;
  // the held instruction's FPGA counts as busy, so it can never be regranted on its own handshake
  always_comb
    for (int f = 0; f < NUM_FPGA; f++)
      busy[f] = (bcnt[f] != '0) | (out_valid & (out_fpga == FW'(f)));
  always_comb
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = bus.req_valid[i] & !busy[bus.req_fpga[i*FW +: FW]] & free;
  always_comb begin
    found = 1'b0;
    win   = '0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found    = 1'b1;
        win      = SW'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end
  assign bus.req_ready = rst ? '0 : gnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_fpga  <= '0;
      out_instr <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
      issue_cnt <= '0;
      for (int f = 0; f < NUM_FPGA; f++) bcnt[f] <= '0;
    end else begin
      if (found) begin
        out_valid <= 1'b1;
        out_fpga  <= bus.req_fpga[win*FW +: FW];
        out_instr <= bus.req_instr[win*INSTR_W +: INSTR_W];
        out_src   <= win;
        rr_ptr    <= (win == SW'(NUM_REQ-1)) ? '0 : win + 1'b1;
      end else if (hs)
        out_valid <= 1'b0;
      if (hs) issue_cnt <= issue_cnt + 1'b1;
      for (int f = 0; f < NUM_FPGA; f++)
        bcnt[f] <= (hs && out_fpga == FW'(f)) ? BW'(GATE_LAT) : bcnt[f] - BW'(bcnt[f] != '0);
    end
  assign bus.out_valid = out_valid;
  assign bus.out_fpga  = out_fpga;
  assign bus.out_instr = out_instr;
  assign bus.out_src   = out_src;
  assign bus.fpga_busy = busy;
  assign bus.issue_cnt = issue_cnt;
endmodule
